// File: rtl/sdram_arb_pkg.sv
// Shared types for the multi-channel SDRAM arbiter: arbitration mode,
// arbiter FSM state and the owner record kept per outstanding read.
package sdram_arb_pkg;

  localparam int MAX_CH = 8;

  // Index width for n channels; never below 1 bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_IDX_W = ch_idx_w(MAX_CH);

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [CH_IDX_W-1:0] ch;
    logic                burst;
  } owner_t;

endpackage

// File: rtl/sdram_arb_owner_fifo.sv
// In-order owner FIFO: one entry per read the controller has accepted,
// popped when the last response beat of that read returns.
module sdram_arb_owner_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  owner_t din_i,
  input  logic   pop_i,
  output owner_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  owner_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;
  assign head_o  = mem[rd_ptr];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= din_i;
  end

  // Pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter_mc.sv
// N-channel SDRAM request arbiter with fixed-priority or round-robin grant
// and in-order routing of read responses back to the issuing channel.
// Optional build macro SDRAM_ARB_STATS_EN adds per-channel grant counters;
// without it stat_grants_o is tied to zero.
//
// state | meaning
// IDLE  | no grant held; arbitrate when controller is ready
// ISSUE | command of granted channel presented until ack or master drop
module sdram_arbiter_mc
  import sdram_arb_pkg::*;
#(
  parameter int        NUM_CH     = 2,
  parameter int        ADDR_W     = 24,
  parameter int        DATA_W     = 16,
  parameter int        BURST_LEN  = 8,
  parameter int        FIFO_DEPTH = 4,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_rd_i,
  input  logic [NUM_CH-1:0]        ch_wr_i,
  input  logic [NUM_CH-1:0]        ch_burst_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_x16_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  input  logic [NUM_CH*2-1:0]      ch_wmask_i,
  output logic [NUM_CH-1:0]        ch_ack_o,
  output logic [NUM_CH-1:0]        ch_resp_valid_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic                     sdram_rd_o,
  output logic                     sdram_wr_o,
  output logic                     sdram_burst_o,
  output logic [ADDR_W-1:0]        sdram_addr_x16_o,
  output logic [DATA_W-1:0]        sdram_wdata_o,
  output logic [1:0]               sdram_wmask_o,
  input  logic                     sdram_rdy_i,
  input  logic                     sdram_ack_i,
  input  logic                     sdram_resp_valid_i,
  input  logic [DATA_W-1:0]        sdram_rdata_i,
  output logic                     err_o,
  output logic [NUM_CH*32-1:0]     stat_grants_o
);

  localparam int G_W    = ch_idx_w(NUM_CH);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  arb_state_e        state_q, state_d;
  logic [G_W-1:0]    grant_q, grant_d;
  logic [G_W-1:0]    rr_q, rr_d;
  logic [BEAT_W-1:0] beat_q;
  logic              err_q;

  logic [NUM_CH-1:0] eligible;
  logic              any_elig;
  logic [G_W-1:0]    winner;

  int                g_idx;
  logic              g_rd, g_wr, g_burst;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  owner_t            fifo_din, fifo_head;
  logic              resp_hit, last_beat;

  // Reads need a free owner slot; writes bypass the FIFO entirely.
  always_comb begin
    eligible = ch_wr_i | (ch_rd_i & {NUM_CH{~fifo_full}});
    any_elig = |eligible;
  end

  // Winner search: scan from rr_q (round-robin) or from 0 (fixed priority).
  always_comb begin : p_arb
    int base;
    int idx;
    logic found;
    base   = (ARB_MODE == ARB_RR) ? int'(rr_q) : 0;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (base + k) % NUM_CH;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = G_W'(idx);
      end
    end
  end

  // Request fields of the currently granted channel.
  always_comb begin
    g_idx   = int'(grant_q);
    g_rd    = ch_rd_i[g_idx];
    g_wr    = ch_wr_i[g_idx];
    g_burst = ch_burst_i[g_idx];
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state and command outputs; rd+wr together is treated as a write.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    fifo_push        = 1'b0;
    fifo_din         = '0;
    ch_ack_o         = '0;
    sdram_rd_o       = 1'b0;
    sdram_wr_o       = 1'b0;
    sdram_burst_o    = 1'b0;
    sdram_addr_x16_o = '0;
    sdram_wdata_o    = '0;
    sdram_wmask_o    = '0;
    case (state_q)
      IDLE: begin
        if (sdram_rdy_i && any_elig) begin
          grant_d = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sdram_wr_o       = g_wr;
        sdram_rd_o       = g_rd & ~g_wr;
        sdram_burst_o    = g_burst & g_rd & ~g_wr;
        sdram_addr_x16_o = ch_addr_x16_i[g_idx*ADDR_W +: ADDR_W];
        sdram_wdata_o    = ch_wdata_i[g_idx*DATA_W +: DATA_W];
        sdram_wmask_o    = ch_wmask_i[g_idx*2 +: 2];
        if (!(g_rd || g_wr)) begin
          state_d = IDLE;
        end else if (sdram_ack_i) begin
          // A reset in this cycle aborts the command without acking it.
          ch_ack_o       = rst_i ? '0 : (ONE_HOT0 << grant_q);
          fifo_push      = g_rd & ~g_wr;
          fifo_din.ch    = CH_IDX_W'(grant_q);
          fifo_din.burst = g_burst;
          rr_d           = (g_idx == NUM_CH - 1) ? '0 : grant_q + 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sdram_arb_owner_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (fifo_push),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Response routing: beats go to the oldest outstanding read's owner.
  always_comb begin
    resp_hit        = sdram_resp_valid_i & ~fifo_empty;
    last_beat       = ~fifo_head.burst | (beat_q == BEAT_W'(BURST_LEN - 1));
    fifo_pop        = resp_hit & last_beat;
    ch_resp_valid_o = resp_hit ? (ONE_HOT0 << fifo_head.ch) : '0;
    ch_rdata_o      = resp_hit ? sdram_rdata_i : '0;
  end

  // Beat counter within the head read; cleared when that read completes.
  always_ff @(posedge clk_i) begin
    if (rst_i)                beat_q <= '0;
    else if (resp_hit)        beat_q <= last_beat ? '0 : beat_q + 1'b1;
  end

  // Sticky error: a beat arrived with nothing outstanding to own it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 err_q <= 1'b0;
    else if (sdram_resp_valid_i && fifo_empty) err_q <= 1'b1;
  end

  assign err_o = err_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_CH];

  // Per-channel grant counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_i)            grant_cnt_q[i] <= '0;
      else if (ch_ack_o[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
    end
  end

  // Flatten counters onto the stats bus.
  always_comb begin
    stat_grants_o = '0;
    for (int i = 0; i < NUM_CH; i++) stat_grants_o[i*32 +: 32] = grant_cnt_q[i];
  end
`else
  assign stat_grants_o = '0;
`endif

endmodule

// File: tb/tb_sdram_arbiter_mc.sv
// Self-checking bench for sdram_arbiter_mc: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_sdram_arbiter_mc;
  import sdram_arb_pkg::*;

  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic [NUM_CH-1:0]        ch_rd_i = '0, ch_wr_i = '0, ch_burst_i = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_x16_i = '0;
  logic [NUM_CH*DATA_W-1:0] ch_wdata_i = '0;
  logic [NUM_CH*2-1:0]      ch_wmask_i = '0;
  logic [NUM_CH-1:0]        ch_ack_o, ch_resp_valid_o;
  logic [DATA_W-1:0]        ch_rdata_o;
  logic                     sdram_rd_o, sdram_wr_o, sdram_burst_o;
  logic [ADDR_W-1:0]        sdram_addr_x16_o;
  logic [DATA_W-1:0]        sdram_wdata_o;
  logic [1:0]               sdram_wmask_o;
  logic                     sdram_rdy_i = 1'b0, sdram_ack_i = 1'b0, sdram_resp_valid_i = 1'b0;
  logic [DATA_W-1:0]        sdram_rdata_i = '0;
  logic                     err_o;
  logic [NUM_CH*32-1:0]     stat_grants_o;

  always #5 clk_i = ~clk_i;

  sdram_arbiter_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ARB_MODE(ARB_RR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_rd_i(ch_rd_i), .ch_wr_i(ch_wr_i), .ch_burst_i(ch_burst_i),
    .ch_addr_x16_i(ch_addr_x16_i), .ch_wdata_i(ch_wdata_i), .ch_wmask_i(ch_wmask_i),
    .ch_ack_o(ch_ack_o), .ch_resp_valid_o(ch_resp_valid_o), .ch_rdata_o(ch_rdata_o),
    .sdram_rd_o(sdram_rd_o), .sdram_wr_o(sdram_wr_o), .sdram_burst_o(sdram_burst_o),
    .sdram_addr_x16_o(sdram_addr_x16_o), .sdram_wdata_o(sdram_wdata_o),
    .sdram_wmask_o(sdram_wmask_o), .sdram_rdy_i(sdram_rdy_i), .sdram_ack_i(sdram_ack_i),
    .sdram_resp_valid_i(sdram_resp_valid_i), .sdram_rdata_i(sdram_rdata_i),
    .err_o(err_o), .stat_grants_o(stat_grants_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending grant, an RR pointer, a queue of
  // outstanding reads (owner, burst), beats delivered to the head, counters.
  typedef struct {
    int ch;
    bit burst;
  } own_s;

  bit          m_busy = 0;
  int          m_g = 0;
  int          m_rr = 0;
  int          m_beat = 0;
  bit          m_err = 0;
  int unsigned m_stats [NUM_CH];
  own_s        m_q [$];
  bit          ack_seen [NUM_CH];

  // Per-cycle compare against the model, then advance the model one clock.
  always @(negedge clk_i) begin
    bit rdq, wrq, hit, full0, found;
    logic [NUM_CH-1:0] e_ack, e_rv;
    int g, idx;
    g   = m_g;
    rdq = m_busy && ch_rd_i[g] && !ch_wr_i[g];
    wrq = m_busy && ch_wr_i[g];
    hit = sdram_resp_valid_i && (m_q.size() > 0);
    e_ack = (!rst_i && (rdq || wrq) && sdram_ack_i) ? NUM_CH'(1 << g) : '0;
    e_rv  = hit ? NUM_CH'(1 << m_q[0].ch) : '0;

    chk("sdram_rd", sdram_rd_o, rdq);
    chk("sdram_wr", sdram_wr_o, wrq);
    chk("sdram_burst", sdram_burst_o, rdq && ch_burst_i[g]);
    chk("sdram_addr", sdram_addr_x16_o, m_busy ? ch_addr_x16_i[g*ADDR_W +: ADDR_W] : '0);
    chk("sdram_wdata", sdram_wdata_o, m_busy ? ch_wdata_i[g*DATA_W +: DATA_W] : '0);
    chk("sdram_wmask", sdram_wmask_o, m_busy ? ch_wmask_i[g*2 +: 2] : '0);
    chk("ch_ack", ch_ack_o, e_ack);
    chk("resp_valid", ch_resp_valid_o, e_rv);
    chk("rdata", ch_rdata_o, hit ? sdram_rdata_i : '0);
    chk("err", err_o, m_err);
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef SDRAM_ARB_STATS_EN
      chk("stats", stat_grants_o[i*32 +: 32], m_stats[i]);
`else
      chk("stats", stat_grants_o[i*32 +: 32], 0);
`endif
      ack_seen[i] = ch_ack_o[i];
    end

    if (rst_i) begin
      m_busy = 0; m_rr = 0; m_beat = 0; m_err = 0; m_q.delete();
      for (int i = 0; i < NUM_CH; i++) m_stats[i] = 0;
    end else begin
      full0 = (m_q.size() >= FIFO_DEPTH);
      if (sdram_resp_valid_i) begin
        if (m_q.size() > 0) begin
          m_beat++;
          if (!m_q[0].burst || m_beat == BURST_LEN) begin
            void'(m_q.pop_front());
            m_beat = 0;
          end
        end else m_err = 1;
      end
      if (m_busy) begin
        if (!(rdq || wrq)) m_busy = 0;
        else if (sdram_ack_i) begin
          if (rdq) m_q.push_back('{ch: g, burst: ch_burst_i[g]});
          m_rr = (g + 1) % NUM_CH;
          m_stats[g]++;
          m_busy = 0;
        end
      end else if (sdram_rdy_i) begin
        found = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          idx = (m_rr + k) % NUM_CH;
          if (!found && (ch_wr_i[idx] || (ch_rd_i[idx] && !full0))) begin
            found = 1; m_g = idx; m_busy = 1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; ch_rd_i = '0; ch_wr_i = '0; ch_burst_i = '0;
    sdram_ack_i = 1'b0; sdram_resp_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  bit req_act [NUM_CH];

  // Random masters hold a request until acked (rarely aborting); controller
  // side randomizes ready/ack and returns beats only for outstanding reads.
  task automatic drive_random(input bit allow_new);
    int r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_act[i]) begin
        if (ack_seen[i] || $urandom_range(0, 99) < 2) begin
          ch_rd_i[i] = 1'b0; ch_wr_i[i] = 1'b0; req_act[i] = 0;
        end
      end else if (allow_new && $urandom_range(0, 99) < 30) begin
        r = $urandom_range(0, 99);
        ch_wr_i[i]    = (r < 40) || (r >= 95);
        ch_rd_i[i]    = (r >= 40);
        ch_burst_i[i] = 1'($urandom_range(0, 1));
        ch_addr_x16_i[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        ch_wdata_i[i*DATA_W +: DATA_W]    = DATA_W'($urandom);
        ch_wmask_i[i*2 +: 2]              = 2'($urandom);
        req_act[i] = 1;
      end
    end
    sdram_rdy_i        = ($urandom_range(0, 99) < 75);
    sdram_ack_i        = ($urandom_range(0, 99) < 50);
    sdram_resp_valid_i = (m_q.size() > 0) && ($urandom_range(0, 99) < 40);
    sdram_rdata_i      = DATA_W'($urandom);
  endtask

  initial begin
    int order [$];
    bit got, wr_at_ack;

    // Single read from ch0, data routed back to ch0.
    do_reset();
    chk("t1_reset_err", err_o, 0);
    ch_rd_i[0] = 1'b1; ch_addr_x16_i[0 +: ADDR_W] = 24'h000100; sdram_rdy_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t1_rd_not_same_cycle", sdram_rd_o, 0);
    @(posedge clk_i); #1; sdram_ack_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t1_rd", sdram_rd_o, 1);
    chk("t1_addr", sdram_addr_x16_o, 24'h000100);
    chk("t1_ack", ch_ack_o, 3'b001);
    @(posedge clk_i); #1;
    ch_rd_i = '0; sdram_ack_i = 1'b0; sdram_resp_valid_i = 1'b1; sdram_rdata_i = 16'hBEEF;
    @(negedge clk_i); #1;
    chk("t1_resp_valid", ch_resp_valid_o, 3'b001);
    chk("t1_rdata", ch_rdata_o, 16'hBEEF);
    chk("t1_no_ack", ch_ack_o, 3'b000);
    @(posedge clk_i); #1; sdram_resp_valid_i = 1'b0;

    // Round-robin between ch0 and ch1 held high; fills the FIFO.
    do_reset();
    ch_rd_i = 3'b011; sdram_ack_i = 1'b1; sdram_rdy_i = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk_i); #1;
      for (int i = 0; i < NUM_CH; i++) if (ch_ack_o[i]) order.push_back(i);
    end
    chk("t2_grant_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("t2_g0", order[0], 0); chk("t2_g1", order[1], 1);
      chk("t2_g2", order[2], 0); chk("t2_g3", order[3], 1);
    end

    // FIFO full: reads held, a write still goes through.
    repeat (3) begin
      @(negedge clk_i); #1;
      chk("t4_rd_held", sdram_rd_o, 0);
    end
    @(posedge clk_i); #1; ch_wr_i[1] = 1'b1;
    got = 0; wr_at_ack = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i); #1;
      if (ch_ack_o[1]) begin got = 1; wr_at_ack = sdram_wr_o; end
    end
    chk("t4_wr_ack", got, 1);
    chk("t4_wr_cmd", wr_at_ack, 1);
    @(posedge clk_i); #1; ch_wr_i[1] = 1'b0; ch_rd_i[1] = 1'b0;
    @(negedge clk_i); #1;
`ifdef SDRAM_ARB_STATS_EN
    chk("t6_stats_ch0", stat_grants_o[0 +: 32], 2);
    chk("t6_stats_ch1", stat_grants_o[32 +: 32], 3);
`else
    chk("t6_stats_ch0", stat_grants_o[0 +: 32], 0);
    chk("t6_stats_ch1", stat_grants_o[32 +: 32], 0);
`endif
    @(posedge clk_i); #1; sdram_resp_valid_i = 1'b1; sdram_rdata_i = 16'h1234;
    @(negedge clk_i); #1;
    chk("t4_pop_owner", ch_resp_valid_o, 3'b001);
    @(posedge clk_i); #1; sdram_resp_valid_i = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk_i); #1;
      if (ch_ack_o[0]) got = 1;
    end
    chk("t4_rd_after_pop", got, 1);

    // Response with nothing outstanding sets a sticky error.
    do_reset();
    sdram_resp_valid_i = 1'b1; sdram_rdata_i = 16'hDEAD;
    @(negedge clk_i); #1;
    chk("t5_no_strobe", ch_resp_valid_o, 3'b000);
    @(posedge clk_i); #1; sdram_resp_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i); #1;
      chk("t5_err_sticky", err_o, 1);
    end
    do_reset();
    @(negedge clk_i); #1;
    chk("t5_err_cleared", err_o, 0);

    // Randomized traffic, then a drain phase with no new requests.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) req_act[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_i); #1;
      drive_random(1'b1);
    end
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i); #1;
      drive_random(1'b0);
    end
    @(posedge clk_i); #1;
    ch_rd_i = '0; ch_wr_i = '0; sdram_resp_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
